// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard: inhibit, request-to-send, then
// eleven device clock falling edges shift out data, parity and stop and
// sample the ack bit. All pins are open-drain, driven through pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  localparam int              INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]     TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0]     TO_MAX   = 20'hF_FFFF;

  // Synchroniser and edge-detect flops
  logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
  logic data_meta_reg, data_sync_reg;

  // Control state
  logic [2:0]       state_reg, state_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [19:0]      to_cnt_reg, to_cnt_next;
  logic [3:0]       fe_idx_reg, fe_idx_next;
  logic [7:0]       data_reg, data_next;
  logic             parity_reg, parity_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic fe;
  logic bus_idle;
  logic to_expired;

  // Bring the asynchronous pins into the clk domain; idle bus level is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk_in;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= ps2_data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign fe         = clk_prev_reg & ~clk_sync_reg;
  assign bus_idle   = clk_sync_reg & data_sync_reg;
  assign to_expired = (to_cnt_reg >= TO_LAST);

  // Next-state logic for the transmit sequencer
  always_comb begin
    state_next   = state_reg;
    inh_cnt_next = inh_cnt_reg;
    fe_idx_next  = fe_idx_reg;
    data_next    = data_reg;
    parity_next  = parity_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;
    // Saturating count of cycles since the last reload; never wraps
    to_cnt_next  = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + 20'd1;

    case (state_reg)
      ST_IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        busy_next    = 1'b0;
        // A start coinciding with a completion pulse is dropped, not queued
        if (tx_start && !done_reg && !error_reg) begin
          state_next   = ST_INHIBIT;
          data_next    = tx_data;
          parity_next  = ~^tx_data;
          busy_next    = 1'b1;
          clk_oe_next  = 1'b1;
          inh_cnt_next = '0;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_reg == INH_LAST) begin
          // Release clock and pull data low: start bit / request-to-send
          state_next   = ST_RTS;
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b1;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end

      ST_RTS: begin
        fe_idx_next = 4'd0;
        to_cnt_next = 20'd0;
        state_next  = ST_SHIFT;
      end

      ST_SHIFT: begin
        // A device edge takes priority over an expiring timeout
        if (fe) begin
          to_cnt_next = 20'd0;
          fe_idx_next = fe_idx_reg + 4'd1;
          if (fe_idx_reg < 4'd8) begin
            data_oe_next = ~data_reg[fe_idx_reg[2:0]];
          end else if (fe_idx_reg == 4'd8) begin
            data_oe_next = ~parity_reg;
          end else if (fe_idx_reg == 4'd9) begin
            data_oe_next = 1'b0;
          end else if (!data_sync_reg) begin
            state_next = ST_WAIT_IDLE;
          end else begin
            state_next   = ST_ERR;
            clk_oe_next  = 1'b0;
            data_oe_next = 1'b0;
            error_next   = 1'b1;
            busy_next    = 1'b0;
          end
        end else if (to_expired) begin
          state_next   = ST_ERR;
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          error_next   = 1'b1;
          busy_next    = 1'b0;
        end
      end

      ST_WAIT_IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (fe) begin
          to_cnt_next = 20'd0;
        end
        if (bus_idle) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else if (!fe && to_expired) begin
          state_next = ST_ERR;
          error_next = 1'b1;
          busy_next  = 1'b0;
        end
      end

      ST_ERR: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        busy_next    = 1'b0;
        state_next   = ST_IDLE;
      end

      default: begin
        state_next   = ST_IDLE;
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases both lines immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= 20'd0;
      fe_idx_reg  <= 4'd0;
      data_reg    <= 8'd0;
      parity_reg  <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      fe_idx_reg  <= fe_idx_next;
      data_reg    <= data_next;
      parity_reg  <= parity_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  assign tx_busy     = busy_reg;
  assign tx_done     = done_reg;
  assign tx_error    = error_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain bus with a behavioural keyboard that
// clocks frames in, plus a frame model derived from the PS/2 framing rules.
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Wired-AND open-drain lines with pull-ups
  assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_in = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: pulse counts, inhibit length, ownership and busy/done timing
  int   done_cnt = 0, err_cnt = 0, inh_run = 0, last_inh_len = 0;
  int   inh_starts = 0, oe_conflict = 0, done_busy_bad = 0;
  logic busy_prev = 1'b0, clk_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      if (!(busy_prev && !tx_busy)) done_busy_bad++;
    end
    if (tx_error) err_cnt++;
    if (ps2_clk_oe && ps2_data_oe) oe_conflict++;
    if (ps2_clk_oe && !clk_oe_prev) inh_starts++;
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh_len = inh_run;
      inh_run = 0;
    end
    busy_prev   = tx_busy;
    clk_oe_prev = ps2_clk_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected 11-bit frame as the device sees it: start, data LSB first, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10]  = 1'b1;
    return f;
  endfunction

  int dev_fe_cnt = 0;
  int last_fe_cyc = 0;

  // Keyboard model: waits for request-to-send, clocks 11 bits, samples on rising edges
  task automatic device_frame(input int stop_after, input bit do_ack,
                              output logic [10:0] rx, output bit started);
    int w;
    rx = '1;
    started = 1'b0;
    w = 0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) return;
    started = 1'b1;
    rx[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      dev_fe_cnt  = i;
      last_fe_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i == stop_after) return;
      if (i <= 10) rx[i] = ps2_data_in;
      if (i == 10 && do_ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end else if (i < 11) begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Bounded wait for the end of a transaction; captures the line enables one cycle later
  task automatic wait_end(output bit seen, output int at_cyc, output logic [1:0] oe_after);
    int n;
    seen = 1'b0;
    at_cyc = 0;
    oe_after = 2'b11;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (tx_done || tx_error) begin
        seen = 1'b1;
        at_cyc = cyc;
        @(negedge clk);
        oe_after = {ps2_clk_oe, ps2_data_oe};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_send(input logic [7:0] b, input string name);
    logic [10:0] rx, exp;
    bit st, seen;
    int at, d0, e0, bb0, oc0;
    logic [1:0] oe_after;
    d0 = done_cnt; e0 = err_cnt; bb0 = done_busy_bad; oc0 = oe_conflict;
    exp = frame_of(b);
    start_tx(b);
    fork
      device_frame(0, 1'b1, rx, st);
      wait_end(seen, at, oe_after);
    join
    repeat (5) @(negedge clk);
    n_checks++;
    if (!(st && seen)) begin
      n_fail++;
      $display("FAIL %s handshake: started=%0d ended=%0d expected 1 1", name, st, seen);
    end
    n_checks++;
    if (rx !== exp) begin
      n_fail++;
      $display("FAIL %s frame: got %b expected %b", name, rx, exp);
    end
    n_checks++;
    if (last_inh_len !== INH) begin
      n_fail++;
      $display("FAIL %s inhibit_len: got %0d expected %0d", name, last_inh_len, INH);
    end
    n_checks++;
    if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
      n_fail++;
      $display("FAIL %s pulses: done=%0d error=%0d expected 1 0", name, done_cnt - d0, err_cnt - e0);
    end
    n_checks++;
    if (done_busy_bad !== bb0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_fall: bad=%0d busy=%b expected 0 0", name, done_busy_bad - bb0, tx_busy);
    end
    n_checks++;
    if (oe_conflict !== oc0 || oe_after !== 2'b00) begin
      n_fail++;
      $display("FAIL %s bus_owner: conflicts=%0d oe_after=%b expected 0 00", name, oe_conflict - oc0, oe_after);
    end
    $display("send %s: byte=%h frame=%b", name, b, rx);
  endtask

  task automatic test_send_ed();
    logic [10:0] want;
    test_send(8'hED, "send_ed");
    want = 11'b11_1110_1101_0;
    n_checks++;
    if (frame_of(8'hED) !== want) begin
      n_fail++;
      $display("FAIL ed_model: got %b expected %b", frame_of(8'hED), want);
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] rx;
    bit st, seen;
    int at, d0, e0;
    logic [1:0] oe_after;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    fork
      device_frame(0, 1'b0, rx, st);
      wait_end(seen, at, oe_after);
    join
    repeat (5) @(negedge clk);
    n_checks++;
    if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
      n_fail++;
      $display("FAIL no_ack pulses: error=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
    end
    n_checks++;
    if (oe_after !== 2'b00) begin
      n_fail++;
      $display("FAIL no_ack release: oe=%b expected 00", oe_after);
    end
    $display("no_ack: frame=%b errors=%0d", rx, err_cnt - e0);
  endtask

  task automatic test_timeout();
    logic [10:0] rx;
    bit st, seen;
    int at, d0, e0, lat;
    logic [1:0] oe_after;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hA5);
    fork
      device_frame(4, 1'b1, rx, st);
      wait_end(seen, at, oe_after);
    join
    lat = at - last_fe_cyc;
    repeat (5) @(negedge clk);
    n_checks++;
    if (!seen || lat < TO - 3 || lat > TO + 3) begin
      n_fail++;
      $display("FAIL timeout latency: got %0d expected %0d..%0d", lat, TO - 3, TO + 3);
    end
    n_checks++;
    if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0 || oe_after !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout outcome: error=%0d done=%0d oe=%b expected 1 0 00",
               err_cnt - e0, done_cnt - d0, oe_after);
    end
    $display("timeout: error %0d cycles after last device edge", lat);
  endtask

  task automatic test_back_to_back();
    logic [10:0] rx;
    bit st, seen;
    int d0, s0, n;
    d0 = done_cnt; s0 = inh_starts;
    seen = 1'b0;
    start_tx(8'h3C);
    fork
      device_frame(0, 1'b1, rx, st);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        while (!seen && n < 3000) begin
          @(negedge clk);
          n++;
          if (tx_done || tx_error) begin
            seen = 1'b1;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
          end
        end
      end
    join
    repeat (60) @(negedge clk);
    n_checks++;
    if (rx !== frame_of(8'h3C)) begin
      n_fail++;
      $display("FAIL b2b frame: got %b expected %b", rx, frame_of(8'h3C));
    end
    n_checks++;
    if ((done_cnt - d0) !== 1 || (inh_starts - s0) !== 1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b ignored_start: done=%0d frames=%0d busy=%b expected 1 1 0",
               done_cnt - d0, inh_starts - s0, tx_busy);
    end
    $display("back_to_back: frame=%b frames_started=%0d", rx, inh_starts - s0);
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] rx;
    bit st;
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    dev_fe_cnt = 0;
    start_tx(8'h00);
    fork
      device_frame(6, 1'b1, rx, st);
      begin
        n = 0;
        while (dev_fe_cnt != 6 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (ps2_data_oe !== 1'b1 || tx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset pre: data_oe=%b busy=%b expected 1 1", ps2_data_oe, tx_busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
          n_fail++;
          $display("FAIL midreset outputs: got %b expected 00000",
                   {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
        end
        rst_n = 1'b1;
      end
    join
    repeat (100) @(negedge clk);
    n_checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset quiet: done=%0d error=%0d busy=%b expected 0 0 0",
               done_cnt - d0, err_cnt - e0, tx_busy);
    end
    $display("reset_mid_frame: outputs cleared");
    test_send(8'hFF, "send_ff_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      test_send(b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send(8'hF4, "send_f4");
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
